// File: rtl/reg_bank_wb.sv
// 32 x DATA_W register bank behind a one-deep write-back stage, with all registers driven out in parallel.
// Define REG_BANK_WB_FWD_EN to forward the pending write-back value onto Q. This cuts the write latency to one edge.
module reg_bank_wb #(
  parameter int DATA_W  = 32,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 WE,
  input  logic [4:0]           RD,
  input  logic [DATA_W-1:0]    DIN,
  output logic [32*DATA_W-1:0] Q,
  output logic [31:0]          PEND,
  output logic                 WB_VALID
);

  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  // Address and data are held while WE=0, so X on RD or DIN cannot enter the stage.
  always_comb begin
    wb_valid_d = WE && !(R0_ZERO && (RD == 5'd0));
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (WE) begin
      wb_addr_d = RD;
      wb_data_d = DIN;
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign WB_VALID = wb_valid_q;

  for (genvar gi = 0; gi < 32; gi++) begin : g_reg
    logic              reg_q;
    logic [DATA_W-1:0] bank_q;
    logic              hit;
    logic [DATA_W-1:0] rd_val;

    assign hit = wb_valid_q && (wb_addr_q == 5'(gi));

    always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
        bank_q <= '0;
      end else if (hit) begin
        bank_q <= wb_data_q;
      end
    end

`ifdef REG_BANK_WB_FWD_EN
    assign rd_val = hit ? wb_data_q : bank_q;
`else
    assign rd_val = bank_q;
`endif

    assign reg_q = 1'b0;
    assign PEND[gi] = hit;
    assign Q[DATA_W*gi +: DATA_W] = (R0_ZERO && (gi == 0)) ? '0 : (rd_val | {DATA_W{reg_q}});
  end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb. Expected register values are queued when a write is driven and compared when they become due on Q.
module tb_reg_bank_wb;
  localparam int DATA_W = 32;
`ifdef REG_BANK_WB_FWD_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                 Clk = 1'b0;
  logic                 Clr;
  logic                 WE;
  logic [4:0]           RD;
  logic [DATA_W-1:0]    DIN;
  logic [32*DATA_W-1:0] Q;
  logic [31:0]          PEND;
  logic                 WB_VALID;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    int          idx;
    logic [31:0] val;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  always #5 Clk = ~Clk;

  reg_bank_wb #(.DATA_W(DATA_W), .R0_ZERO(1'b1)) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .WE       (WE),
    .RD       (RD),
    .DIN      (DIN),
    .Q        (Q),
    .PEND     (PEND),
    .WB_VALID (WB_VALID)
  );

  function automatic logic [31:0] qreg(input int i);
    return Q[DATA_W*i +: DATA_W];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_drain();
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      check($sformatf("sb_r%0d_c%0d", e.idx, cyc), qreg(e.idx), e.val);
    end
  endtask

  task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] din, input bit track);
    @(negedge Clk);
    WE  = we;
    RD  = rd;
    DIN = din;
    if (track) sb_q.push_back(exp_t'{idx: int'(rd), val: (rd == 5'd0) ? 32'h0 : din, due: cyc + LAT});
    @(posedge Clk);
    #1;
    cyc++;
    $display("cyc %0d: WE=%b RD=%0d DIN=%h -> PEND=%h WB_VALID=%b", cyc, we, rd, din, PEND, WB_VALID);
    sb_drain();
  endtask

  task automatic idle();
    step(1'b0, 5'bx, 32'bx, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Clr = 1'b1;
    WE  = 1'b0;
    RD  = 5'bx;
    DIN = 32'bx;
    #2 Clr = 1'b0;
    @(posedge Clk);
    #1;
    check("rst_q",    32'(|Q), 32'h0);
    check("rst_pend", PEND, 32'h0);
    check("rst_wbv",  32'(WB_VALID), 32'h0);
    @(negedge Clk);
    Clr = 1'b1;
    repeat (5) idle();
    check("idle_q",    32'(|Q), 32'h0);
    check("idle_pend", PEND, 32'h0);
    check("idle_wbv",  32'(WB_VALID), 32'h0);

    // Single write to r5
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    check("wr5_pend", PEND, 32'h0000_0020);
    check("wr5_wbv",  32'(WB_VALID), 32'h1);
    check("wr5_q_n",  qreg(5), (LAT == 1) ? 32'hDEADBEEF : 32'h0);
    idle();
    check("wr5_q_n1",   qreg(5), 32'hDEADBEEF);
    check("wr5_pend_0", PEND, 32'h0);
    check("wr5_wbv_0",  32'(WB_VALID), 32'h0);

    // Writes to r0 are dropped
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
    check("r0_wbv",  32'(WB_VALID), 32'h0);
    check("r0_pend", PEND, 32'h0);
    check("r0_q",    qreg(0), 32'h0);
    idle();
    check("r0_q_after", qreg(0), 32'h0);

    // Back-to-back writes, same address then different addresses
    step(1'b1, 5'd7, 32'h11111111, 1'b1);
    step(1'b1, 5'd7, 32'h22222222, 1'b1);
    check("b2b_pend7", PEND, 32'h0000_0080);
    idle();
    idle();
    check("b2b_r7", qreg(7), 32'h22222222);
    step(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1);
    step(1'b1, 5'd4, 32'h5A5A5A5A, 1'b1);
    check("b2b_pend4", PEND, 32'h0000_0010);
    idle();
    idle();
    check("b2b_r3", qreg(3), 32'hA5A5A5A5);
    check("b2b_r4", qreg(4), 32'h5A5A5A5A);

    // Reset lands between capture and commit
    step(1'b1, 5'd9, 32'h12345678, 1'b0);
    check("mid_wbv_set", 32'(WB_VALID), 32'h1);
    WE = 1'b0;
    #2 Clr = 1'b0;
    #1;
    check("mid_wbv_rst",  32'(WB_VALID), 32'h0);
    check("mid_pend_rst", PEND, 32'h0);
    check("mid_q_rst",    32'(|Q), 32'h0);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    Clr = 1'b1;
    idle();
    check("mid_r9",  qreg(9), 32'h0);
    check("mid_wbv", 32'(WB_VALID), 32'h0);

    // Full sweep r1..r31
    for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1);
    idle();
    idle();
    for (int i = 0; i < 32; i++)
      check($sformatf("sweep_r%0d", i), qreg(i), (i == 0) ? 32'h0 : 32'h100 + 32'(i));
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- 32-entry × 32-bit general-register bank with a one-deep write-back register in front of it.
- Drives all 32 register values in parallel as a flat bus. The bus feeds the 32-input operand-select multiplexers directly, one mux per read port.
- Register r0 always reads zero, matching SPARC %g0.
- Writes are staged for one cycle, then committed into the bank. Software-visible write latency is fixed and deterministic.

Parameters:
- DATA_W, 32, width of each register and of the write data. Must match the downstream 32-bit mux width.
- R0_ZERO, 1: 1 = r0 hardwired to zero and writes to it dropped; 0 = r0 is an ordinary register.

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Clr  input  1  asynchronous active-low reset
- WE  input  1  write request qualifier for the current cycle
- RD  input  5  destination register address
- DIN  input  DATA_W  write data
- Q  output  32*DATA_W  flat register image; register i on Q[DATA_W*i +: DATA_W], feeding mux input Ii
- PEND  output  32  one-hot mask of the register held in the write-back stage; all zero when the stage is empty
- WB_VALID  output  1  write-back stage holds a write not yet committed

Behaviour:
- Reset is asynchronous and active-low on Clr; the single clock is Clk. While Clr=0:
  - all 32 bank registers are 0
  - wb_valid = 0, wb_addr = 0, wb_data = 0
  - Q = all zero, PEND = 0, WB_VALID = 0
- Release is synchronous to the next Clk edge; there are no partial states.
- Capture (edge N):
  - wb_valid <= WE & ~(R0_ZERO & RD==0)
  - wb_addr <= RD; wb_data <= DIN
  - When WE=0, wb_valid goes to 0; addr and data may be left unchanged.
- Commit (edge N+1): if wb_valid, bank[wb_addr] <= wb_data. Commit happens every cycle unconditionally; there is no stall input.
- Latency: data presented with WE=1 in cycle N is visible on Q after edge N+1, i.e. 2 edges. Q is registered from the bank only; there is no combinational path from DIN to Q (base configuration).
- Capture and commit in the same edge: the stage shifts by one slot, like a pipeline.
  - Back-to-back writes to the same address commit in order; the last one wins.
  - Writes to different addresses on consecutive cycles are both committed; none is lost.
- PEND[i] = wb_valid & (wb_addr==i); PEND[0] is always 0 when R0_ZERO=1.
- WB_VALID = wb_valid.
- Q[0 +: DATA_W] is the constant 0 when R0_ZERO=1, regardless of bank content.
- A write with RD=0 and R0_ZERO=1 never sets WB_VALID and never alters the bank.
- Reset asserted while a write is pending: the pending write is discarded and is not committed after release.
- X on RD or DIN while WE=0 must not corrupt any state.

Optional Feature:
- Macro: REG_BANK_WB_FWD_EN.
- With it defined:
  - For the register addressed by wb_addr while wb_valid=1, Q drives wb_data instead of bank content. Effective write latency becomes 1 edge.
  - The forwarding is a combinational path from wb registers to Q only; DIN still has no path to Q.
  - r0 remains zero when R0_ZERO=1.
- Without it: Q reflects committed bank content only, with the 2-edge latency above.
- PEND and WB_VALID behave identically in both builds.

Test Plan:
- Reset then idle: hold Clr=0, pulse Clk, release, 5 idle cycles -> Q=0 for all 32 registers, PEND=0, WB_VALID=0.
- Single write: WE=1, RD=5, DIN=0xDEADBEEF at cycle N, then WE=0. Response per edge:
  - after edge N: PEND=0x00000020, WB_VALID=1, Q register 5 still 0 (0xDEADBEEF with FWD_EN)
  - after edge N+1: Q register 5 = 0xDEADBEEF, PEND=0
- r0 protection: WE=1, RD=0, DIN=0xFFFFFFFF -> WB_VALID stays 0 and Q register 0 = 0 throughout.
- Back-to-back writes:
  - Same address: RD=7 with 0x11111111, then RD=7 with 0x22222222 -> final Q register 7 = 0x22222222.
  - Different addresses: RD=3 with 0xA5A5A5A5, then RD=4 with 0x5A5A5A5A -> both committed, no loss.
- Reset mid-operation: WE=1, RD=9, DIN=0x12345678, assert Clr low before the commit edge, then release -> register 9 = 0, WB_VALID=0.
- Full sweep: write value 0x100+i to every RD=1..31 on consecutive cycles -> two edges after the last write, Q register i = 0x100+i for i=1..31 and register 0 = 0.
